// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and lock-state type, common to the
// timing generator and the sync receiver.
package vga_timing_pkg;

    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_H_START  = 144;
    localparam int VGA_V_START  = 35;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    localparam int VGA_CNT_W = 11;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } lock_state_t;

endpackage

// File: rtl/vga_sync_sampler.sv
// Input capture for the VGA receiver: samples sync/RGB on pix_en, keeps the
// previous sync sample and produces registered rise flags one clk later.
module vga_sync_sampler (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic        sample,
    output logic        h_rise,
    output logic        v_rise,
    output logic [11:0] rgb
);

    logic [1:0]  sync_in;
    logic [1:0]  rise;
    logic        strobe_reg;
    logic        sample_reg;
    logic [11:0] rgb_cap_reg;
    logic [11:0] rgb_reg;

    assign sync_in = {vsync, hsync};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic cur_reg;
            logic prev_reg;
            logic rise_reg;

            // Both history bits reset high so a sync already asserted at
            // reset release is not mistaken for an edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cur_reg  <= 1'b1;
                    prev_reg <= 1'b1;
                    rise_reg <= 1'b0;
                end else begin
                    if (pix_en) begin
                        cur_reg  <= sync_in[gi];
                        prev_reg <= cur_reg;
                    end
                    rise_reg <= strobe_reg & cur_reg & ~prev_reg;
                end
            end

            assign rise[gi] = rise_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_reg  <= 1'b0;
            sample_reg  <= 1'b0;
            rgb_cap_reg <= '0;
            rgb_reg     <= '0;
        end else begin
            strobe_reg <= pix_en;
            sample_reg <= strobe_reg;
            if (pix_en) begin
                rgb_cap_reg <= {red, green, blue};
            end
            if (strobe_reg) begin
                rgb_reg <= rgb_cap_reg;
            end
        end
    end

    assign sample = sample_reg;
    assign h_rise = rise[0];
    assign v_rise = rise[1];
    assign rgb    = rgb_reg;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receiver: rebuilds h/v counters from sync edges, checks line and frame
// lengths, locks after clean frames and emits active-window pixels.
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_START     = VGA_H_START,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_START     = VGA_V_START,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err
);

    localparam logic [VGA_CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [VGA_CNT_W-1:0] CNT_ONE   = VGA_CNT_W'(1);
    localparam logic [VGA_CNT_W-1:0] H_TOTAL_C = VGA_CNT_W'(H_TOTAL);
    localparam logic [VGA_CNT_W-1:0] V_TOTAL_C = VGA_CNT_W'(V_TOTAL);
    localparam logic [VGA_CNT_W-1:0] H_START_C = VGA_CNT_W'(H_START);
    localparam logic [VGA_CNT_W-1:0] H_END_C   = VGA_CNT_W'(H_START + H_ACTIVE);
    localparam logic [VGA_CNT_W-1:0] V_START_C = VGA_CNT_W'(V_START);
    localparam logic [VGA_CNT_W-1:0] V_END_C   = VGA_CNT_W'(V_START + V_ACTIVE);
    localparam logic [3:0]           LOCK_C    = 4'(LOCK_FRAMES);

    logic                 sample;
    logic                 h_rise;
    logic                 v_rise;
    logic [11:0]          sample_rgb;

    logic [VGA_CNT_W-1:0] hcnt_reg, hcnt_next;
    logic [VGA_CNT_W-1:0] vcnt_reg, vcnt_next;
    logic                 vs_pend_reg, vs_pend_next;
    lock_state_t          state_reg, state_next;
    logic [3:0]           good_reg, good_next;
    logic                 frame_bad_reg, frame_bad_next;

    logic                 boundary;
    logic                 line_err;
    logic                 frame_err;
    logic                 err_any;
    logic                 active;
    logic [VGA_CNT_W-1:0] x_full;
    logic [VGA_CNT_W-1:0] y_full;

    vga_sync_sampler u_sampler (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en),
        .hsync  (hsync_in),
        .vsync  (vsync_in),
        .red    (red_in),
        .green  (green_in),
        .blue   (blue_in),
        .sample (sample),
        .h_rise (h_rise),
        .v_rise (v_rise),
        .rgb    (sample_rgb)
    );

    // Counters and length checks for the sample currently presented.
    always_comb begin
        hcnt_next    = hcnt_reg;
        vcnt_next    = vcnt_reg;
        vs_pend_next = vs_pend_reg;
        boundary     = 1'b0;
        line_err     = 1'b0;
        frame_err    = 1'b0;
        if (sample) begin
            if (h_rise) begin
                hcnt_next = '0;
                line_err  = (hcnt_reg + CNT_ONE) != H_TOTAL_C;
            end else if (hcnt_reg != CNT_MAX) begin
                hcnt_next = hcnt_reg + CNT_ONE;
                line_err  = (hcnt_reg == CNT_MAX - CNT_ONE);
            end

            // A pending vsync is applied on the next hsync rise, which may be
            // the one arriving together with it.
            if (h_rise && (vs_pend_reg || v_rise)) begin
                boundary     = 1'b1;
                frame_err    = (vcnt_reg + CNT_ONE) != V_TOTAL_C;
                vcnt_next    = '0;
                vs_pend_next = 1'b0;
            end else begin
                if (v_rise) begin
                    vs_pend_next = 1'b1;
                end
                if (h_rise && vcnt_reg != CNT_MAX) begin
                    vcnt_next = vcnt_reg + CNT_ONE;
                end
            end
        end
    end

    assign err_any = sample && (state_reg != SEARCH) && (line_err || frame_err);

    always_comb begin
        state_next     = state_reg;
        good_next      = good_reg;
        frame_bad_next = frame_bad_reg;
        if (sample) begin
            unique case (state_reg)
                SEARCH: begin
                    if (boundary) begin
                        state_next     = VERIFY;
                        good_next      = '0;
                        frame_bad_next = 1'b0;
                    end
                end
                VERIFY: begin
                    if (boundary) begin
                        frame_bad_next = 1'b0;
                        if (frame_bad_reg || line_err || frame_err) begin
                            good_next = '0;
                        end else begin
                            good_next = good_reg + 4'd1;
                        end
                        if (good_next == LOCK_C) begin
                            state_next = LOCKED;
                        end
                    end else if (line_err) begin
                        frame_bad_next = 1'b1;
                    end
                end
                LOCKED: begin
                    if (line_err || frame_err) begin
                        state_next = SEARCH;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_reg      <= '0;
            vcnt_reg      <= '0;
            vs_pend_reg   <= 1'b0;
            state_reg     <= SEARCH;
            good_reg      <= '0;
            frame_bad_reg <= 1'b0;
        end else begin
            hcnt_reg      <= hcnt_next;
            vcnt_reg      <= vcnt_next;
            vs_pend_reg   <= vs_pend_next;
            state_reg     <= state_next;
            good_reg      <= good_next;
            frame_bad_reg <= frame_bad_next;
        end
    end

    // Window test uses the post-update state so a pixel in an erroring sample
    // is already suppressed.
    assign active = (state_next == LOCKED)
                 && (hcnt_next >= H_START_C) && (hcnt_next < H_END_C)
                 && (vcnt_next >= V_START_C) && (vcnt_next < V_END_C);
    assign x_full = hcnt_next - H_START_C;
    assign y_full = vcnt_next - V_START_C;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            pix_valid   <= sample && active;
            frame_start <= boundary;
            timing_err  <= err_any;
            if (sample && active) begin
                pix_x   <= x_full[9:0];
                pix_y   <= y_full[9:0];
                pix_rgb <= sample_rgb;
            end
        end
    end

    assign locked = (state_reg == LOCKED);

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Receive-side counterpart of the VGA timing generator: samples a 640x480 VGA stream (positive-polarity `Hsynq`/`Vsynq` plus 4-bit RGB) on a pixel-rate enable and rebuilds horizontal and vertical counters from the sync edges. It checks line and frame lengths against the fixed 800x525 timing, locks after a run of clean frames, and emits per-pixel coordinates and data for the active window. It sits at the input of the display-loopback and capture path, where it checks the generator end to end.

## Interface
- `H_TOTAL`, 800: pixels per line, including sync and porches.
- `V_TOTAL`, 525: lines per frame.
- `H_START`, 144: h-count of the first active pixel.
- `H_ACTIVE`, 640: active pixels per line.
- `V_START`, 35: v-count of the first active line.
- `V_ACTIVE`, 480: active lines per frame.
- `LOCK_FRAMES`, 2: consecutive clean frames needed to lock. Range 1..15.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `pix_en` in 1: one-`clk` pixel strobe (25 MHz rate). It may also be held high continuously.
- `hsync_in` in 1: horizontal sync, active high.
- `vsync_in` in 1: vertical sync, active high.
- `red_in`, `green_in`, `blue_in` in 4 each: pixel colour.
- `pix_valid` out 1: a one-`clk` pulse per active pixel.
- `pix_x` out 10: 0..639. Meaningful only while `pix_valid` is high.
- `pix_y` out 10: 0..479. Meaningful only while `pix_valid` is high.
- `pix_rgb` out 12: {R,G,B}. Meaningful only while `pix_valid` is high.
- `frame_start` out 1: a one-`clk` pulse when a frame boundary is accepted.
- `locked` out 1: level, high while in LOCKED.
- `timing_err` out 1: a one-`clk` pulse on any line or frame length mismatch.

## Operation
- **Sampling.** Inputs are sampled only on `clk` edges where `pix_en`=1. With `pix_en`=0, all state holds and all pulses are 0.
- **Sync edge detection.** An hsync or vsync rise is a 0 in the previous sample followed by a 1 in the current sample.
- **Horizontal counter.** `hcnt` is 11 bits.
  - On an hsync rise, `hcnt` loads 0 and that sample is h-count 0.
  - Otherwise `hcnt` increments, saturating at 2047.
- **Line check.** On each hsync rise, measured line length = old `hcnt` + 1. Any value other than `H_TOTAL` is a line error.
  - `hcnt` reaching 2047 is also a line error, flagged once per saturation.
- **Vertical counter.** `vcnt` is 11 bits.
  - A vsync rise sets `vs_pend`.
  - At the next hsync rise (including one in the same sample), `vcnt` loads 0, `vs_pend` clears and `frame_start` pulses. The frame check uses frame length = old `vcnt` + 1, which must equal `V_TOTAL`.
  - With `vs_pend` clear, each hsync rise increments `vcnt`, saturating at 2047.
- **Lock state machine.** States are SEARCH, VERIFY and LOCKED.
  - SEARCH: the first accepted frame boundary moves to VERIFY with `good`=0. No length checks are made in SEARCH.
  - VERIFY: at each frame boundary, if the frame just ended had no line or frame error, `good` increments; otherwise `good` clears. When `good` reaches `LOCK_FRAMES`, move to LOCKED.
  - LOCKED: any line or frame error returns to SEARCH immediately, in the same sample.
- **`timing_err`** pulses for every error detected in VERIFY or LOCKED, never in SEARCH.
- **Active window.** A pixel is active when LOCKED, `H_START` ≤ `hcnt` < `H_START`+`H_ACTIVE`, and `V_START` ≤ `vcnt` < `V_START`+`V_ACTIVE`.
  - `pix_x` = `hcnt` − `H_START`.
  - `pix_y` = `vcnt` − `V_START`.
  - `pix_rgb` is the RGB of that same sample.
- **Reset** at any time, including mid-frame, returns to SEARCH with all counters and flags at 0.

## Timing
- **Reset values:**
  - `pix_valid`, `frame_start`, `locked`, `timing_err` = 0.
  - `pix_x`, `pix_y` = 0; `pix_rgb` = 0.
  - Previous-sample sync registers = 1, so no false edge is seen after reset.
- **Latency.** All outputs are registered. The response to the sample taken in `pix_en` cycle N appears on `clk` edge N+2, fixed, for any `pix_en` spacing ≥ 1.
- **Pulse width.** Every pulse is exactly one `clk` wide, even when `pix_en` is held high.
- **`locked` transitions:**
  - Rises with the `frame_start` pulse of the LOCK_FRAMES-th clean boundary.
  - Falls with the `timing_err` pulse that caused the exit.
- **`pix_valid` after lock.** The first `pix_valid` is for (0,0) of the next frame.

## Structure
- Shared package `vga_timing_pkg` holds:
  - The 800/525/144/35/640/480 constants, shared with the generator.
  - The state enum {SEARCH, VERIFY, LOCKED}.
  - Counter width `VGA_CNT_W` = 11.
- One sub-module, `vga_sync_sampler`, covers input sample registers, previous-sample registers and rise detection. It outputs `h_rise`, `v_rise`, the sampled RGB and a sample strobe.
- Counters, the lock FSM and the output stage live in the top.

## Test plan
- **Nominal lock.** Drive the generator's 800x525 stream, `pix_en` every 4th `clk`. Required: `locked` rises at the 2nd clean boundary after the first vsync; the next frame gives 307200 `pix_valid` pulses; first pixel (0,0), last (639,479).
- **Short line.** While locked, one line is 799 pixels. Required: one `timing_err`, `locked`=0, state SEARCH, no `pix_valid` until relock 3 frame boundaries later.
- **Frame length.** Drive a 524-line frame during VERIFY with `good`=1. Required: `good` clears, no lock, `timing_err`=1 once.
- **Coincident syncs.** Hsync and vsync rise in the same sample. Required: `vcnt`=0 in that sample, `frame_start` at N+2; a vsync mid-line applies at the next hsync rise.
- **Lost hsync.** Hold `hsync_in`=0 while locked. Required: `timing_err` once when `hcnt`=2047, `locked`=0, no repeat pulses.
- **Reset mid-frame.** Pulse `rst` at pixel (300,200). Required: all outputs 0 asynchronously; relock after 2 clean frames; continuous `pix_en` gives 2-`clk` latency with one-`clk` pulses.
